// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared types, default timing and round-robin pick for the sonar scheduler
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP
    } state_t;

    localparam int MAX_SENSORS    = 16;
    localparam int DEF_N_SENSORS  = 4;
    localparam int DEF_CLK_PER_US = 40;
    localparam int DEF_TRIG_US    = 20;
    localparam int DEF_TIMEOUT_US = 30000;
    localparam int DEF_GAP_US     = 10000;

    // First set mask bit strictly after 'last', scanning upward and wrapping at n.
    // The last-served sensor itself is considered only after a full wrap, so a
    // single-bit mask keeps re-selecting that sensor. Empty mask returns 'last'.
    function automatic logic [3:0] next_sensor(input logic [MAX_SENSORS-1:0] mask,
                                               input logic [3:0]             last,
                                               input int                     n);
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= MAX_SENSORS; i++) begin
            if (!found && i <= n) begin
                idx = int'(last) + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (mask[idx[3:0]]) begin
                    pick  = idx[3:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - free-running prescaler producing a one-clk microsecond tick
module us_tick_gen #(
    parameter int CLK_PER_US = 40
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            PW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_US - 1);

    logic [PW-1:0] count;

    // Prescaler counts 0..CLK_PER_US-1 and wraps; runs continuously from reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + PW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/sonar_scheduler.sv
// rtl/sonar_scheduler.sv - round-robin HC-SR04 ping scheduler and echo timer (option: ECHO_SYNC_EN)
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter  int N_SENSORS  = DEF_N_SENSORS,
    parameter  int CLK_PER_US = DEF_CLK_PER_US,
    parameter  int TRIG_US    = DEF_TRIG_US,
    parameter  int TIMEOUT_US = DEF_TIMEOUT_US,
    parameter  int GAP_US     = DEF_GAP_US,
    localparam int IDW        = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1,
    localparam int CW         = $clog2(TIMEOUT_US + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] sensor_mask,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trig,
    output logic                 busy,
    output logic [IDW-1:0]       cur_id,
    output logic                 result_valid,
    output logic [IDW-1:0]       result_id,
    output logic [CW-1:0]        result_us,
    output logic                 result_timeout
);

    // The shared tick counter also times TRIG and GAP, so it must be wide
    // enough for whichever of the three intervals is longest.
    localparam int TW   = $clog2(TRIG_US + 1);
    localparam int GW   = $clog2(GAP_US + 1);
    localparam int CNTW = (CW >= TW && CW >= GW) ? CW : ((TW >= GW) ? TW : GW);

    state_t              state;
    state_t              state_nxt;
    logic                tick;
    logic [CNTW-1:0]     cnt;
    logic                cnt_en;
    logic [IDW-1:0]      last_id;
    logic [IDW-1:0]      sel_id;
    logic [IDW-1:0]      trig_id;
    logic                select;
    logic                report;
    logic [CW-1:0]       rep_us;
    logic                rep_to;
    logic [N_SENSORS-1:0] echo_s;
    logic                echo_cur;
    logic                echo_prev;
    logic                echo_rise;
    logic                echo_fall;

    us_tick_gen #(
        .CLK_PER_US (CLK_PER_US)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

`ifdef ECHO_SYNC_EN
    logic [N_SENSORS-1:0] echo_sync1;
    logic [N_SENSORS-1:0] echo_sync2;

    // Two-flop synchronizer per echo pin; delays both edges equally so widths are unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_sync1 <= '0;
            echo_sync2 <= '0;
        end else begin
            echo_sync1 <= echo;
            echo_sync2 <= echo_sync1;
        end
    end

    assign echo_s = echo_sync2;
`else
    assign echo_s = echo;
`endif

    assign sel_id    = IDW'(next_sensor(16'(sensor_mask), 4'(last_id), N_SENSORS));
    assign echo_cur  = echo_s[cur_id];
    assign echo_rise = echo_cur & ~echo_prev;
    assign echo_fall = ~echo_cur & echo_prev;
    assign trig_id   = select ? sel_id : cur_id;
    assign cnt_en    = (state != IDLE) && ((state != MEASURE) || echo_cur);
    assign busy      = (state != IDLE);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the one-cycle report strobe and its payload
    always_comb begin
        state_nxt = state;
        select    = 1'b0;
        report    = 1'b0;
        rep_us    = '0;
        rep_to    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (|sensor_mask)) begin
                    select    = 1'b1;
                    state_nxt = TRIG;
                end
            end
            TRIG: begin
                if (tick && cnt == CNTW'(TRIG_US - 1)) begin
                    state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_nxt = MEASURE;
                end else if (tick && cnt == CNTW'(TIMEOUT_US - 1)) begin
                    report    = 1'b1;
                    rep_to    = 1'b1;
                    state_nxt = GAP;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    report    = 1'b1;
                    rep_us    = cnt[CW-1:0];
                    state_nxt = GAP;
                end else if (tick && echo_cur && cnt == CNTW'(TIMEOUT_US - 1)) begin
                    report    = 1'b1;
                    rep_us    = CW'(TIMEOUT_US);
                    rep_to    = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (tick && cnt == CNTW'(GAP_US - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tick counter: cleared on every state change, otherwise advances on tick
    // (in MEASURE only while the echo is high); limits end each state before wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (tick && cnt_en) begin
            cnt <= cnt + CNTW'(1);
        end
    end

    // Sensor selection, last-served pointer and echo history of the selected sensor
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_id    <= '0;
            last_id   <= IDW'(N_SENSORS - 1);
            echo_prev <= 1'b0;
        end else begin
            if (select) begin
                cur_id <= sel_id;
            end
            if (report) begin
                last_id <= cur_id;
            end
            echo_prev <= select ? echo_s[sel_id] : echo_cur;
        end
    end

    // Trigger pins: one-hot on the serviced sensor for the whole TRIG state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig <= '0;
        end else begin
            trig <= '0;
            if (state_nxt == TRIG) begin
                trig[trig_id] <= 1'b1;
            end
        end
    end

    // Result record: valid pulses once per ping, payload holds until the next report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid   <= 1'b0;
            result_id      <= '0;
            result_us      <= '0;
            result_timeout <= 1'b0;
        end else begin
            result_valid <= report;
            if (report) begin
                result_id      <= cur_id;
                result_us      <= rep_us;
                result_timeout <= rep_to;
            end
        end
    end

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb/tb_sonar_scheduler.sv - scoreboard bench for sonar_scheduler with per-sensor echo responders
module tb_sonar_scheduler;

    localparam int N    = 4;
    localparam int CPU  = 4;
    localparam int TRG  = 20;
    localparam int TMO  = 1000;
    localparam int GAPT = 100;

    // Echo behaviour of each sensor's responder
    localparam int M_NORMAL = 0;
    localparam int M_NONE   = 1;
    localparam int M_LONG   = 2;
    localparam int M_STUCK  = 3;

    typedef struct packed {
        logic [1:0] id;
        logic [9:0] us;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] sensor_mask = 4'b0000;
    logic [3:0] echo = 4'b0000;
    logic [3:0] trig;
    logic       busy;
    logic [1:0] cur_id;
    logic       result_valid;
    logic [1:0] result_id;
    logic [9:0] result_us;
    logic       result_timeout;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   res_cyc = 0;
    int   trig_w = 0;
    int   mode [N];
    int   fall_cyc [N];
    logic [3:0] trig_seen = 4'b0000;
    exp_t exp_q [$];

    sonar_scheduler #(
        .N_SENSORS  (N),
        .CLK_PER_US (CPU),
        .TRIG_US    (TRG),
        .TIMEOUT_US (TMO),
        .GAP_US     (GAPT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sensor_mask    (sensor_mask),
        .echo           (echo),
        .trig           (trig),
        .busy           (busy),
        .cur_id         (cur_id),
        .result_valid   (result_valid),
        .result_id      (result_id),
        .result_us      (result_us),
        .result_timeout (result_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int us, input int to);
        exp_t e;
        e.id = 2'(id);
        e.us = 10'(us);
        e.to = 1'(to);
        exp_q.push_back(e);
    endtask

    task automatic wait_results(input string name, input int left, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > left && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > left) begin
            errors++;
            $display("FAIL %s: %0d results outstanding after %0d cycles, expected %0d", name, exp_q.size(), budget, left);
            exp_q.delete();
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    // Scoreboard monitor: every result pulse pops one expected record
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && result_valid) begin
                res_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: id %0d us %0d timeout %0d, expected no result", result_id, result_us, result_timeout);
                end else begin
                    e = exp_q.pop_front();
                    check("result_id", result_id, e.id);
                    check("result_us", result_us, e.us);
                    check("result_timeout", result_timeout, e.to);
                end
            end
        end
    end

    // Trigger monitor: one-hot at all times, each pulse spans 20 ticks (77..80 clk)
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                trig_w = 0;
            end else if (trig != 4'b0000) begin
                trig_w++;
                trig_seen = trig_seen | trig;
                if ($countones(trig) != 1) begin
                    checks++;
                    errors++;
                    $display("FAIL trig_onehot: got %b, expected one bit set", trig);
                end
            end else if (trig_w != 0) begin
                checks++;
                if (trig_w < (TRG - 1) * CPU + 1 || trig_w > TRG * CPU) begin
                    errors++;
                    $display("FAIL trig_width: got %0d clk, expected 77..80", trig_w);
                end
                trig_w = 0;
            end
        end
    end

    // Echo model of one sensor, reacting to its own trigger pin
    task automatic responder(input int k);
        logic prev_t;
        prev_t = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && trig[k] && !prev_t && mode[k] == M_STUCK) begin
                echo[k] = 1'b1;
            end
            if (!reset && busy && prev_t && !trig[k]) begin
                fall_cyc[k] = cyc;
                if (mode[k] == M_NORMAL || mode[k] == M_LONG) begin
                    repeat (50 * CPU) @(negedge clk);
                    echo[k] = 1'b1;
                    if (mode[k] == M_NORMAL) begin
                        repeat (300 * CPU) @(negedge clk);
                    end else begin
                        repeat (2000 * CPU) @(negedge clk);
                    end
                    echo[k] = 1'b0;
                end else if (mode[k] == M_STUCK) begin
                    repeat ((TMO + 25) * CPU) @(negedge clk);
                    echo[k] = 1'b0;
                end
            end
            prev_t = trig[k];
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mode[i]     = M_NORMAL;
            fall_cyc[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            fork
                automatic int k = i;
                responder(k);
            join_none
        end
    end

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_trig", trig, 0);
        check("reset_busy", busy, 0);
        check("reset_cur_id", cur_id, 0);
        check("reset_result_valid", result_valid, 0);
        check("reset_result_id", result_id, 0);
        check("reset_result_us", result_us, 0);
        check("reset_result_timeout", result_timeout, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Full mask: round-robin 0,1,2,3,0 with 300-tick echoes
        sensor_mask = 4'b1111;
        push(0, 300, 0);
        push(1, 300, 0);
        push(2, 300, 0);
        push(3, 300, 0);
        push(0, 300, 0);
        enable = 1'b1;
        wait_results("rr_all_results", 0, 15000);
        enable = 1'b0;
        wait_idle("rr_all_idle", 1000);

        // Reset in the middle of TRIG: trig drops at once, pointer restarts at sensor 0
        enable = 1'b1;
        n = 0;
        while (trig == 4'b0000 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midtrig_trig_before", trig, 4'b0010);
        check("midtrig_cur_id", cur_id, 1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_trig_async", trig, 0);
        check("reset_busy_async", busy, 0);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Sparse mask 0101: order 0,2,0,2, sensors 1 and 3 never triggered
        trig_seen = 4'b0000;
        sensor_mask = 4'b0101;
        push(0, 300, 0);
        push(2, 300, 0);
        push(0, 300, 0);
        push(2, 300, 0);
        enable = 1'b1;
        wait_results("rr_sparse_results", 0, 10000);
        enable = 1'b0;
        wait_idle("rr_sparse_idle", 1000);
        check("sparse_trig1_never", trig_seen[1], 0);
        check("sparse_trig3_never", trig_seen[3], 0);

        // Timeouts: 3 stuck-high before trig fall, 1 silent, 2 overlong echo
        mode[1] = M_NONE;
        mode[2] = M_LONG;
        mode[3] = M_STUCK;
        sensor_mask = 4'b1110;
        push(3, 0, 1);
        push(1, 0, 1);
        push(2, TMO, 1);
        enable = 1'b1;
        wait_results("timeout_first_two", 1, 12000);
        check("noecho_timeout_latency", res_cyc - fall_cyc[1], TMO * CPU);
        wait_results("timeout_results", 0, 6000);
        enable = 1'b0;
        wait_idle("timeout_idle", 1000);
        mode[1] = M_NORMAL;
        mode[2] = M_NORMAL;
        mode[3] = M_NORMAL;

        // Enable dropped during MEASURE: ping 3 still reports, then block parks in IDLE
        sensor_mask = 4'b1111;
        push(3, 300, 0);
        enable = 1'b1;
        n = 0;
        while (echo[3] == 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("measure_echo_started", echo[3], 1);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_results("enable_drop_result", 0, 3000);
        wait_idle("enable_drop_idle", 1000);
        trig_seen = 4'b0000;
        repeat (2000) @(negedge clk);
        check("enable_drop_stays_idle", busy, 0);
        check("enable_drop_no_trig", trig_seen, 0);

        // Empty mask with enable high never starts a ping
        sensor_mask = 4'b0000;
        enable = 1'b1;
        repeat (500) @(negedge clk);
        check("mask0_busy", busy, 0);
        check("mask0_no_trig", trig_seen, 0);
        enable = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
